// File: rtl/rv32im_muldiv_seq_pkg.sv
// Shared definitions for the RV32 M-extension sequencer: widths, op encodings
// and FSM state encoding.
package rv32im_muldiv_seq_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [4:0] SEL_MUL    = 5'b00001;
  localparam logic [4:0] SEL_MULH   = 5'b00101;
  localparam logic [4:0] SEL_MULHSU = 5'b01001;
  localparam logic [4:0] SEL_MULHU  = 5'b01101;
  localparam logic [4:0] SEL_DIV    = 5'b10001;
  localparam logic [4:0] SEL_DIVU   = 5'b10101;
  localparam logic [4:0] SEL_REM    = 5'b11001;
  localparam logic [4:0] SEL_REMU   = 5'b11101;

  typedef enum logic [2:0] {
    F_MUL    = 3'd0,
    F_MULH   = 3'd1,
    F_MULHSU = 3'd2,
    F_MULHU  = 3'd3,
    F_DIV    = 3'd4,
    F_DIVU   = 3'd5,
    F_REM    = 3'd6,
    F_REMU   = 3'd7
  } funct3_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_DIV   = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Only the eight encodings ending in 2'b01 are real M-ops.
  function automatic logic is_mop(input logic [4:0] sel);
    return sel[0] & ~sel[1];
  endfunction

endpackage

// File: rtl/rv32im_muldiv_seq_if.sv
// EX-stage handshake bundle between the pipeline and the mul/div sequencer.
interface rv32im_muldiv_seq_if;
  import rv32im_muldiv_seq_pkg::*;

  logic            i_start;
  logic [4:0]      i_select;
  logic [XLEN-1:0] i_data1;
  logic [XLEN-1:0] i_data2;
  logic            i_flush;
  logic            o_stall;
  logic            o_result_valid;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_start, i_select, i_data1, i_data2, i_flush,
    input  o_stall, o_result_valid, o_result
  );

  modport slave (
    input  i_start, i_select, i_data1, i_data2, i_flush,
    output o_stall, o_result_valid, o_result
  );

endinterface

// File: rtl/rv32im_div_core.sv
// Iterative radix-2 restoring divider on unsigned magnitudes; one quotient bit
// per step, dividend shifted out of the quotient register as bits come in.
module rv32im_div_core
  import rv32im_muldiv_seq_pkg::*;
#(
  parameter int W  = XLEN,
  parameter int CW = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_quotient,
  output logic [W-1:0] o_remainder,
  output logic         o_last
);

  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_dsr;
  logic [CW-1:0] r_cnt;
  logic [W:0]    w_shift;
  logic [W:0]    w_trial;

  // Remainder stays below the divisor, so W+1 bits are enough for the trial.
  assign w_shift = {r_rem, r_quo[W-1]};
  assign w_trial = w_shift - {1'b0, r_dsr};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dsr <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_dsr <= i_divisor;
      r_cnt <= CW'(W - 1);
    end else if (i_step) begin
      if (w_trial[W]) begin
        r_rem <= w_shift[W-1:0];
        r_quo <= {r_quo[W-2:0], 1'b0};
      end else begin
        r_rem <= w_trial[W-1:0];
        r_quo <= {r_quo[W-2:0], 1'b1};
      end
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;
  assign o_last      = (r_cnt == '0);

endmodule

// File: rtl/rv32im_muldiv_seq.sv
// M-extension sequencer: FSM, registered multiplier, divide special cases and
// sign fix-up around the iterative divider core.
module rv32im_muldiv_seq
  import rv32im_muldiv_seq_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  rv32im_muldiv_seq_if.slave  bus
);

  state_t          r_state;
  state_t          w_state_next;
  funct3_t         r_op;
  funct3_t         w_op_in;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_result;
  logic            r_valid;
  logic            r_neg_q;
  logic            r_neg_r;

  logic            w_sel_ok;
  logic            w_div_sel;
  logic            w_sign_sel;
  logic            w_zero_div;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;

  logic            w_accept;
  logic            w_div_load;
  logic            w_div_step;
  logic            w_mul_load;
  logic            w_fix_load;

  logic [2*XLEN-1:0] w_a_ext;
  logic [2*XLEN-1:0] w_b_ext;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res;

  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic            w_last;
  logic [XLEN-1:0] w_fix_res;

  assign w_op_in    = funct3_t'(bus.i_select[4:2]);
  assign w_sel_ok   = is_mop(bus.i_select);
  assign w_div_sel  = bus.i_select[4];
  assign w_sign_sel = ~bus.i_select[2];
  assign w_zero_div = (bus.i_data2 == '0);
  assign w_ovf      = w_sign_sel & (bus.i_data1 == INT_MIN) & (&bus.i_data2);
  assign w_special  = w_div_sel & (w_zero_div | w_ovf);

  // Overflow case: quotient is the dividend itself (INT_MIN), remainder zero.
  assign w_special_res = bus.i_select[3] ? (w_zero_div ? bus.i_data1 : '0)
                                         : (w_zero_div ? '1 : bus.i_data1);

  assign w_abs1 = (w_sign_sel & bus.i_data1[XLEN-1]) ? -bus.i_data1 : bus.i_data1;
  assign w_abs2 = (w_sign_sel & bus.i_data2[XLEN-1]) ? -bus.i_data2 : bus.i_data2;

  // Modulo 2^64 the product only depends on how each operand is extended.
  assign w_a_ext   = {{XLEN{((r_op == F_MULH) || (r_op == F_MULHSU)) & r_a[XLEN-1]}}, r_a};
  assign w_b_ext   = {{XLEN{(r_op == F_MULH) & r_b[XLEN-1]}}, r_b};
  assign w_prod    = w_a_ext * w_b_ext;
  assign w_mul_res = (r_op == F_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  assign w_fix_res = ((r_op == F_REM) || (r_op == F_REMU))
                     ? (r_neg_r ? -w_rem : w_rem)
                     : (r_neg_q ? -w_quo : w_quo);

  rv32im_div_core #(.W(XLEN), .CW(CNT_W)) u_div_core (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_div_load),
    .i_step      (w_div_step),
    .i_dividend  (w_abs1),
    .i_divisor   (w_abs2),
    .o_quotient  (w_quo),
    .o_remainder (w_rem),
    .o_last      (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.i_flush) begin
      w_state_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (!w_div_sel)    w_state_next = S_MUL;
            else if (w_special) w_state_next = S_DONE;
            else               w_state_next = S_DIV;
          end
        end
        S_MUL:   w_state_next = S_DONE;
        S_DIV:   if (w_last) w_state_next = S_FIXUP;
        S_FIXUP: w_state_next = S_DONE;
        S_DONE:  w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Stall drops in DONE so the pipeline can advance on the result cycle.
  always_comb begin
    w_accept   = 1'b0;
    w_div_step = 1'b0;
    w_mul_load = 1'b0;
    w_fix_load = 1'b0;
    bus.o_stall = ~rst & bus.i_start & bus.i_select[0] & (r_state != S_DONE);
    unique case (r_state)
      S_IDLE:  w_accept   = bus.i_start & w_sel_ok & ~bus.i_flush;
      S_MUL:   w_mul_load = ~bus.i_flush;
      S_DIV:   w_div_step = ~bus.i_flush;
      S_FIXUP: w_fix_load = ~bus.i_flush;
      default: ;
    endcase
    w_div_load = w_accept & w_div_sel & ~w_special;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= F_MUL;
      r_a      <= '0;
      r_b      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= (w_state_next == S_DONE);
      if (w_accept) begin
        r_op    <= w_op_in;
        r_a     <= bus.i_data1;
        r_b     <= bus.i_data2;
        r_neg_q <= w_sign_sel & (bus.i_data1[XLEN-1] ^ bus.i_data2[XLEN-1]);
        r_neg_r <= w_sign_sel & bus.i_data1[XLEN-1];
        if (w_special) r_result <= w_special_res;
      end
      if (w_mul_load) r_result <= w_mul_res;
      if (w_fix_load) r_result <= w_fix_res;
    end
  end

  assign bus.o_result       = r_result;
  assign bus.o_result_valid = r_valid;

endmodule

// File: tb/tb_rv32im_muldiv_seq.sv
// Self-checking bench for rv32im_muldiv_seq: directed table, random ops against
// an arithmetic reference model, and flush/reset/operand-change sequences.
module tb_rv32im_muldiv_seq;
  import rv32im_muldiv_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32im_muldiv_seq_if bus();

  rv32im_muldiv_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [4:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRes;
    int          expLat;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [31:0] lastExp = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference results straight from the ISA definitions using 64-bit arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sp;
    longint unsigned ua, ub, up;
    int              q;
    bit              ovf;
    sa  = longint'($signed(a));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin sp = sa * longint'($signed(b)); return sp[63:32]; end
      3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        q = $signed(a) / $signed(b); return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        q = $signed(a) % $signed(b); return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 2;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] rndOperand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Runs one op from cycle 0 until RESULT_VALID; optionally scrambles operands after accept.
  task automatic applyStimulus(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                               input bit scramble, output logic [31:0] res, output int lat,
                               output int stallErr);
    @(posedge clk); #1;
    bus.i_start  = 1'b1;
    bus.i_select = sel;
    bus.i_data1  = a;
    bus.i_data2  = b;
    lat = -1; stallErr = 0; res = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.o_result_valid) begin
        lat = c;
        res = bus.o_result;
        if (bus.o_stall !== 1'b0) stallErr++;
        break;
      end
      if (bus.o_stall !== 1'b1) stallErr++;
      @(posedge clk); #1;
      if (scramble) begin
        bus.i_data1 = $urandom;
        bus.i_data2 = $urandom;
      end
    end
    @(posedge clk); #1;
    bus.i_start  = 1'b0;
    bus.i_select = 5'b0;
  endtask

  task automatic runOp(input string name, input logic [4:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expRes, input int expLat,
                       input bit scramble);
    logic [31:0] res;
    int lat, stallErr;
    applyStimulus(sel, a, b, scramble, res, lat, stallErr);
    checkOutput({name, " result"}, res, expRes);
    checkOutput({name, " latency"}, lat, expLat);
    checkOutput({name, " stall"}, stallErr, 0);
    lastExp = expRes;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[16];
    logic [2:0]  f;
    logic [31:0] a, b;
    int seen;

    vecs[0]  = '{"MUL 7*-3",        SEL_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2};
    vecs[1]  = '{"MULH min*min",    SEL_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 2};
    vecs[2]  = '{"MULHSU -1*max",   SEL_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2};
    vecs[3]  = '{"MULHU max*max",   SEL_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
    vecs[4]  = '{"DIV -7/2",        SEL_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
    vecs[5]  = '{"REM -7/2",        SEL_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
    vecs[6]  = '{"DIVU 100/7",      SEL_DIVU,   32'd100,        32'd7,         32'd14,        34};
    vecs[7]  = '{"REMU 100/7",      SEL_REMU,   32'd100,        32'd7,         32'd2,         34};
    vecs[8]  = '{"DIVU 5/0",        SEL_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{"REMU 5/0",        SEL_REMU,   32'd5,          32'd0,         32'd5,         1};
    vecs[10] = '{"DIV ovf",         SEL_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{"REM ovf",         SEL_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    vecs[12] = '{"REM -7/0",        SEL_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1};
    vecs[13] = '{"DIVU max/1",      SEL_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 34};
    vecs[14] = '{"DIV min/1",       SEL_DIV,    32'h8000_0000,  32'd1,         32'h8000_0000, 34};
    vecs[15] = '{"REM min/3",       SEL_REM,    32'h8000_0000,  32'd3,         32'hFFFF_FFFE, 34};

    rst = 1'b1;
    bus.i_start  = 1'b1;
    bus.i_select = SEL_MUL;
    bus.i_data1  = 32'd0;
    bus.i_data2  = 32'd0;
    bus.i_flush  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset stall", bus.o_stall, 1'b0);
    checkOutput("reset valid", bus.o_result_valid, 1'b0);
    checkOutput("reset result", bus.o_result, 32'd0);
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    rst = 1'b0;

    // Non-M select with START must be ignored.
    @(posedge clk); #1;
    bus.i_start  = 1'b1;
    bus.i_select = 5'b10000;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_result_valid || bus.o_stall) seen++;
    end
    checkOutput("non-mop ignored", seen, 0);
    @(posedge clk); #1;
    bus.i_start = 1'b0;

    for (int i = 0; i < 16; i++)
      runOp(vecs[i].name, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].expRes, vecs[i].expLat, 1'b0);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = rndOperand();
      b = rndOperand();
      runOp($sformatf("rand%0d f%0d %h %h", i, f, a, b), {f, 2'b01}, a, b,
            refModel(f, a, b), refLatency(f, a, b), 1'b0);
    end

    // Operand and data changes after accept must not disturb the op.
    runOp("DIVU scrambled", SEL_DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b1);
    runOp("DIV scrambled", SEL_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b1);
    runOp("MULHU scrambled", SEL_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 1'b1);

    // Flush a DIV at cycle 10.
    @(posedge clk); #1;
    bus.i_start  = 1'b1;
    bus.i_select = SEL_DIV;
    bus.i_data1  = 32'd1234567;
    bus.i_data2  = 32'd89;
    repeat (10) begin @(posedge clk); #1; end
    bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    bus.i_start = 1'b0;
    @(negedge clk);
    checkOutput("flush valid", bus.o_result_valid, 1'b0);
    checkOutput("flush stall", bus.o_stall, 1'b0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_result_valid) seen++;
    end
    checkOutput("flush no valid", seen, 0);
    checkOutput("flush result hold", bus.o_result, lastExp);
    runOp("MUL after flush", SEL_MUL, 32'd3, 32'd4, 32'd12, 2, 1'b0);

    // Reset at cycle 5 of a DIV.
    @(posedge clk); #1;
    bus.i_start  = 1'b1;
    bus.i_select = SEL_DIV;
    bus.i_data1  = 32'd1000;
    bus.i_data2  = 32'd3;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("stall in reset", bus.o_stall, 1'b0);
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    @(negedge clk);
    checkOutput("midop reset result", bus.o_result, 32'd0);
    checkOutput("midop reset valid", bus.o_result_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_result_valid) seen++;
    end
    checkOutput("reset no valid", seen, 0);
    runOp("MULH after reset", SEL_MULH, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 2, 1'b0);
    runOp("REMU after reset", SEL_REMU, 32'd1000, 32'd3, 32'd1, 34, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
